// File: rtl/bus_slave_pkg.sv
// Shared definitions for the bus slave register bank:
// bus-level polarities, widths, FSM encoding and register indices.
package bus_slave_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    localparam int              REG_IDX_W = 3;
    localparam logic [REG_IDX_W-1:0] R7_IDX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bus_slave_regbank.sv
// Eight-word bus slave: R0..R6 read/write, R7 read-only count of
// completed accesses, fixed-latency response after WAIT_CYCLES.
module bus_slave_regbank
    import bus_slave_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   cs_,
    input  logic [WORD_ADDR_W-1:0] s_addr,
    input  logic                   s_as_,
    input  logic                   s_rw,
    input  logic [WORD_DATA_W-1:0] s_wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   rdy_
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             wait_cnt;
    logic [REG_IDX_W-1:0]   idx;
    logic                   rw;
    logic [WORD_DATA_W-1:0] regs [0:6];
    logic [WORD_DATA_W-1:0] acc_cnt;
    logic                   accept;
    logic                   unused_addr;

    assign unused_addr = ^s_addr[WORD_ADDR_W-1:REG_IDX_W];
    assign accept = (state == IDLE) && (cs_ == ENABLE_) && (s_as_ == ENABLE_);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                // a dropped strobe or select wins over a due response
                if (cs_ == DISABLE_ || s_as_ == DISABLE_)
                    state_nxt = IDLE;
                else if (wait_cnt == 4'd1)
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wait_cnt <= '0;
            idx      <= '0;
            rw       <= READ;
            acc_cnt  <= '0;
            for (int i = 0; i < 7; i++) regs[i] <= '0;
        end else begin
            if (accept) begin
                idx      <= s_addr[REG_IDX_W-1:0];
                rw       <= s_rw;
                wait_cnt <= WAIT_LD;
                if (s_rw == WRITE && s_addr[REG_IDX_W-1:0] != R7_IDX)
                    regs[s_addr[REG_IDX_W-1:0]] <= s_wr_data;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == RESP)
                acc_cnt <= acc_cnt + 32'd1;
        end
    end

    always_comb begin
        rdy_    = DISABLE_;
        rd_data = '0;
        if (state == RESP) begin
            rdy_ = ENABLE_;
            if (rw == READ)
                rd_data = (idx == R7_IDX) ? acc_cnt : regs[idx];
        end
    end

endmodule

// File: tb/tb_bus_slave_regbank.sv
// Randomized bench for bus_slave_regbank: three instances with
// WAIT_CYCLES 0, 1 and 3 checked against a word-array model.
module tb_bus_slave_regbank;

    logic        clk = 1'b0;
    logic        reset_;
    logic [2:0]  cs_;
    logic [29:0] s_addr;
    logic        s_as_;
    logic        s_rw;
    logic [31:0] s_wr_data;
    logic [31:0] rdv [3];
    logic [2:0]  rdy_;

    int          wc [3] = '{0, 1, 3};
    logic [31:0] mregs [3][8];
    logic [31:0] mcnt [3];
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    bus_slave_regbank #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset_(reset_), .cs_(cs_[0]), .s_addr(s_addr),
        .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .rd_data(rdv[0]), .rdy_(rdy_[0]));
    bus_slave_regbank #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset_(reset_), .cs_(cs_[1]), .s_addr(s_addr),
        .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .rd_data(rdv[1]), .rdy_(rdy_[1]));
    bus_slave_regbank #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset_(reset_), .cs_(cs_[2]), .s_addr(s_addr),
        .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .rd_data(rdv[2]), .rdy_(rdy_[2]));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            for (int i = 0; i < 8; i++) mregs[k][i] = 0;
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_rdy"}, 32'(rdy_[k]), 32'd1);
            chk({tag, "_rd"}, rdv[k], 32'd0);
        end
    endtask

    // drive one request and hold it until rdy_; bus fields are
    // scrambled after the accept edge
    task automatic do_acc(input int k, input logic [29:0] a,
                          input logic rw, input logic [31:0] d);
        logic [31:0] exp;
        int          idx;
        @(negedge clk);
        cs_[k] = 1'b0; s_as_ = 1'b0;
        s_addr = a; s_rw = rw; s_wr_data = d;
        @(posedge clk);
        idx = int'(a[2:0]);
        if (rw == 1'b0 && idx != 7) mregs[k][idx] = d;
        exp = (idx == 7) ? mcnt[k] : mregs[k][idx];
        #1;
        s_addr = 30'($urandom); s_rw = 1'($urandom);
        s_wr_data = $urandom;
        for (int i = 0; i <= wc[k]; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            chk($sformatf("lat_u%0d_c%0d", wc[k], i), 32'(rdy_[k]),
                (i == wc[k]) ? 32'd0 : 32'd1);
        end
        if (rw == 1'b1)
            chk($sformatf("rd_u%0d_a%0d", wc[k], idx), rdv[k], exp);
        mcnt[k] = mcnt[k] + 1;
        @(negedge clk);
        cs_[k] = 1'b1; s_as_ = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("rel_u%0d", wc[k]), 32'(rdy_[k]), 32'd1);
    endtask

    task automatic do_abort(input int k, input logic [29:0] a,
                            input logic rw, input logic [31:0] d);
        @(negedge clk);
        cs_[k] = 1'b0; s_as_ = 1'b0;
        s_addr = a; s_rw = rw; s_wr_data = d;
        @(posedge clk);
        if (rw == 1'b0 && a[2:0] != 3'd7) mregs[k][a[2:0]] = d;
        @(negedge clk);
        if ($urandom_range(0, 1) == 0) s_as_ = 1'b1;
        else                           cs_[k] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_u%0d", wc[k]), 32'(rdy_[k]), 32'd1);
        end
        @(negedge clk);
        cs_[k] = 1'b1; s_as_ = 1'b1;
    endtask

    initial begin
        reset_ = 1'b1; cs_ = 3'b111; s_as_ = 1'b1;
        s_addr = '0; s_rw = 1'b1; s_wr_data = '0;
        model_reset();
        #3 reset_ = 1'b0;
        #1 chk_idle("reset");
        @(posedge clk); #2 reset_ = 1'b1;

        // first accept right after release, fixed-latency write/read
        do_acc(1, 30'd3, 1'b0, 32'hDEAD_BEEF);
        do_acc(1, 30'd3, 1'b1, 32'h0);
        chk("deadbeef", mregs[1][3], 32'hDEAD_BEEF);

        // aliasing with zero wait cycles
        do_acc(0, 30'd1, 1'b0, 32'h1234);
        do_acc(0, 30'h0000_0009, 1'b1, 32'h0);

        // R7 is read-only and counts completed accesses
        do_acc(2, 30'd7, 1'b0, 32'h5555);
        do_acc(2, 30'd7, 1'b1, 32'h0);

        // abort one cycle after accept leaves R7 untouched
        do_abort(2, 30'd2, 1'b1, 32'h0);
        do_acc(2, 30'd7, 1'b1, 32'h0);

        for (int n = 0; n < 150; n++) begin
            int k;
            k = $urandom_range(0, 2);
            if (k != 0 && $urandom_range(0, 7) == 0)
                do_abort(k, 30'($urandom), 1'($urandom), $urandom);
            else
                do_acc(k, 30'($urandom), 1'($urandom), $urandom);
        end

        // reset during WAIT
        @(negedge clk);
        cs_[2] = 1'b0; s_as_ = 1'b0; s_addr = 30'd5; s_rw = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_ = 1'b0;
        cs_ = 3'b111; s_as_ = 1'b1;
        #1 chk_idle("midreset");
        model_reset();
        @(posedge clk); #2 reset_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("noresp_after_rst", 32'(rdy_[2]), 32'd1);
        end
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++)
                do_acc(k, 30'(i), 1'b1, 32'h0);

        // R7 wrap via back-door preload
        @(negedge clk);
        u1.acc_cnt = 32'hFFFF_FFFF;
        mcnt[1] = 32'hFFFF_FFFF;
        do_acc(1, 30'd4, 1'b0, 32'hA5A5_0001);
        do_acc(1, 30'd7, 1'b1, 32'h0);
        chk("wrap_model", mcnt[1], 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
